aq_mmu_jtlb_data_ctrl: RTL
==========================

Name: aq_mmu_jtlb_data_ctrl

Overview:
- Requester-side controller for the JTLB data SRAM array (64 entries x 88 bits, two 44-bit ways, per-way write enables).
- Arbitrates the PTW refill write port and the TLB-miss lookup read port.
- Runs an invalidate-all sweep FSM that zeroes every entry.
- Drives the array's cen/wen/idx/din and returns registered read data one cycle after grant.

Parameters:
ENTRY_NUM, 64, number of array entries; sweep walks 0..ENTRY_NUM-1
IDX_W, 6, used index width; upper bits of the 9-bit array index are driven 0
WAY_W, 44, width of one way; the array word is 2*WAY_W

Ports:
forever_cpuclk  input  1  single clock for the block
cpurst  input  1  asynchronous reset, active-high
refill_req  input  1  write one way of one entry
refill_idx  input  6  refill entry index
refill_way  input  1  0: bits[43:0], 1: bits[87:44]
refill_data  input  44  refill payload
refill_gnt  output  1  refill accepted this cycle (combinational)
lkup_req  input  1  read both ways of one entry
lkup_idx  input  6  lookup entry index
lkup_gnt  output  1  lookup accepted this cycle (combinational)
lkup_data_vld  output  1  lkup_data valid; one cycle after lkup_gnt
lkup_data  output  88  read data {way1, way0}
inv_all_req  input  1  start invalidate-all (pulse)
inv_all_busy  output  1  sweep in progress
inv_all_done  output  1  one-cycle pulse at sweep end
jtlb_data_cen  output  1  array chip enable, active-high
jtlb_data_wen  output  2  per-way write enable; 00 = read
jtlb_data_idx  output  9  array index; {3'b0, idx[5:0]}
jtlb_data_din  output  88  array write data
jtlb_data_dout  input  88  array read data; valid the cycle after a read enable

Behaviour:
- Reset values: FSM IDLE, sweep counter 0, all outputs 0, lkup_data 0.
- Priority: sweep > refill > lookup.
  - refill_gnt = refill_req & !inv_all_busy.
  - lkup_gnt = lkup_req & !inv_all_busy & !refill_req.
- Refill grant:
  - cen=1, wen = refill_way ? 2'b10 : 2'b01.
  - idx = refill_idx.
  - din = {refill_data, refill_data}.
- Lookup grant:
  - cen=1, wen=00, idx=lkup_idx, din=0.
  - lkup_data_vld=1 on the next cycle; lkup_data=jtlb_data_dout in that cycle.
- Idle: cen=0, wen=00, idx=0, din=0.
- FSM IDLE:
  - inv_all_req=1 -> SWEEP; counter=0.
  - A refill/lookup in the same cycle is still granted.
- FSM SWEEP:
  - Each cycle: cen=1, wen=11, idx=counter, din=0, counter+1.
  - At counter==ENTRY_NUM-1 -> DONE.
  - inv_all_busy=1 in SWEEP and DONE.
- FSM DONE: inv_all_done=1 for one cycle -> IDLE.
- Latency: inv_all_req accepted at cycle 0; writes at cycles 1..64; done at cycle 65. Busy is 1 for cycles 1..65.
- inv_all_req while busy: ignored, no restart, no second done.
- Held requests: refill/lookup held while busy receive no grant; requesters keep req asserted until gnt.
- Read-after-write: refill at cycle N to idx k, lookup of idx k granted at N+1, returns new data at N+2.
- Lookup outstanding when a sweep starts: lkup_data_vld still fires next cycle with pre-sweep data.
- Reset mid-sweep: returns to IDLE immediately, counter 0, no done pulse; array contents undefined.

Optional Feature:
- Macro: AQ_MMU_JTLB_DATA_HOLD_EN.
- Defined:
  - lkup_data is a register loaded from jtlb_data_dout in the lkup_data_vld cycle.
  - It holds until the next lookup's vld cycle, so data is stable at vld+1 and later.
- Undefined:
  - lkup_data is a combinational pass-through of jtlb_data_dout, meaningful only while lkup_data_vld=1.
  - No 88-bit holding register.

Decomposition:
- Package aq_mmu_jtlb_pkg:
  - JTLB_ENTRY_NUM, JTLB_IDX_W, JTLB_WAY_W.
  - Way-select constants WEN_WAY0=2'b01, WEN_WAY1=2'b10, WEN_ALL=2'b11.
  - Sweep FSM state enum {IDLE, SWEEP, DONE}.
- Sub-module aq_mmu_jtlb_inv_sweep: FSM plus counter; outputs busy, done, sweep_idx, sweep_wr.
- Arbitration and datapath stay in the top module.

Test Plan:
- Refill idx=5, way=1, data=44'hABC -> cen=1, wen=10, idx=9'd5, din[87:44]=44'hABC. Lookup idx 5 next cycle -> lkup_data[87:44]=44'hABC two cycles after the refill.
- refill_req and lkup_req in the same cycle -> refill_gnt=1, lkup_gnt=0; lookup granted the following cycle.
- inv_all_req pulse -> 64 consecutive writes with wen=11, din=0, idx 0..63; inv_all_done at cycle 65; lookups of idx 0 and 63 afterwards return 88'h0.
- lkup_req held during sweep -> lkup_gnt=0 for cycles 1..65, granted at cycle 66; second inv_all_req at cycle 10 -> exactly one done pulse.
- cpurst asserted at sweep cycle 30 -> busy=0, cen=0 immediately; no done pulse; a new inv_all_req restarts from idx 0.
- With AQ_MMU_JTLB_DATA_HOLD_EN: after a lookup returning X, drive jtlb_data_dout with unrelated values -> lkup_data stays X. Without the macro -> lkup_data tracks jtlb_data_dout.

Source files
------------

// File: rtl/aq_mmu_jtlb_pkg.sv
// Shared constants and types for the JTLB data-array controller.
// Contents:
//   JTLB_ENTRY_NUM / JTLB_IDX_W / JTLB_WAY_W : array geometry
//   JTLB_ARR_IDX_W                           : physical array index width
//   WEN_*                                    : per-way write-enable encodings
//   sweep_state_e                            : invalidate-all FSM states
package aq_mmu_jtlb_pkg;

  localparam int unsigned JTLB_ENTRY_NUM = 64;
  localparam int unsigned JTLB_IDX_W     = 6;
  localparam int unsigned JTLB_WAY_W     = 44;
  localparam int unsigned JTLB_ARR_IDX_W = 9;

  localparam logic [1:0] WEN_READ = 2'b00;
  localparam logic [1:0] WEN_WAY0 = 2'b01;
  localparam logic [1:0] WEN_WAY1 = 2'b10;
  localparam logic [1:0] WEN_ALL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/aq_mmu_jtlb_inv_sweep.sv
// Invalidate-all sweep engine: walks entry 0..ENTRY_NUM-1, one write per cycle, then
// pulses done for one cycle. Requests arriving while busy are dropped.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   inv_all_req  : start pulse, honoured only in IDLE
//   busy         : high in SWEEP and DONE
//   done         : one-cycle pulse after the last write
//   sweep_wr     : a sweep write is issued this cycle
//   sweep_idx    : entry written this cycle
module aq_mmu_jtlb_inv_sweep
  import aq_mmu_jtlb_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = JTLB_ENTRY_NUM,
  parameter int unsigned IDX_W     = JTLB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv_all_req,
  output logic             busy,
  output logic             done,
  output logic             sweep_wr,
  output logic [IDX_W-1:0] sweep_idx
);

  sweep_state_e     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    sweep_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_all_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        busy     = 1'b1;
        sweep_wr = 1'b1;
        if (cnt_q == IDX_W'(ENTRY_NUM - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sweep_idx = cnt_q;

endmodule

// File: rtl/aq_mmu_jtlb_data_ctrl.sv
// JTLB data-array requester controller. Arbitrates the sweep, PTW refill writes and
// TLB-miss lookup reads onto one SRAM port (priority sweep > refill > lookup) and
// returns lookup data the cycle after grant.
// Optional feature: AQ_MMU_JTLB_DATA_HOLD_EN keeps lkup_data stable after the valid
// cycle; otherwise lkup_data is a pass-through of the array output.
// Ports:
//   forever_cpuclk, cpurst           : clock, asynchronous active-high reset
//   refill_req/idx/way/data, _gnt    : single-way write request and grant
//   lkup_req/idx, lkup_gnt           : two-way read request and grant
//   lkup_data_vld, lkup_data         : read return {way1, way0}
//   inv_all_req/busy/done            : invalidate-all control and status
//   jtlb_data_cen/wen/idx/din/dout   : SRAM array interface
module aq_mmu_jtlb_data_ctrl
  import aq_mmu_jtlb_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = JTLB_ENTRY_NUM,
  parameter int unsigned IDX_W     = JTLB_IDX_W,
  parameter int unsigned WAY_W     = JTLB_WAY_W
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst,
  input  logic                      refill_req,
  input  logic [IDX_W-1:0]          refill_idx,
  input  logic                      refill_way,
  input  logic [WAY_W-1:0]          refill_data,
  output logic                      refill_gnt,
  input  logic                      lkup_req,
  input  logic [IDX_W-1:0]          lkup_idx,
  output logic                      lkup_gnt,
  output logic                      lkup_data_vld,
  output logic [2*WAY_W-1:0]        lkup_data,
  input  logic                      inv_all_req,
  output logic                      inv_all_busy,
  output logic                      inv_all_done,
  output logic                      jtlb_data_cen,
  output logic [1:0]                jtlb_data_wen,
  output logic [JTLB_ARR_IDX_W-1:0] jtlb_data_idx,
  output logic [2*WAY_W-1:0]        jtlb_data_din,
  input  logic [2*WAY_W-1:0]        jtlb_data_dout
);

  localparam int unsigned PadW = JTLB_ARR_IDX_W - IDX_W;

  logic             sweep_wr;
  logic [IDX_W-1:0] sweep_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             lkup_data_vld_q;

  aq_mmu_jtlb_inv_sweep #(
    .ENTRY_NUM (ENTRY_NUM),
    .IDX_W     (IDX_W)
  ) u_inv_sweep (
    .clk         (forever_cpuclk),
    .rst         (cpurst),
    .inv_all_req (inv_all_req),
    .busy        (inv_all_busy),
    .done        (inv_all_done),
    .sweep_wr    (sweep_wr),
    .sweep_idx   (sweep_idx)
  );

  // Refill blocks lookup even when it is itself blocked by the sweep.
  assign refill_gnt = refill_req & ~inv_all_busy;
  assign lkup_gnt   = lkup_req & ~inv_all_busy & ~refill_req;

  always_comb begin
    jtlb_data_cen = 1'b0;
    jtlb_data_wen = WEN_READ;
    sel_idx       = '0;
    jtlb_data_din = '0;
    if (sweep_wr) begin
      jtlb_data_cen = 1'b1;
      jtlb_data_wen = WEN_ALL;
      sel_idx       = sweep_idx;
    end else if (refill_gnt) begin
      jtlb_data_cen = 1'b1;
      jtlb_data_wen = refill_way ? WEN_WAY1 : WEN_WAY0;
      sel_idx       = refill_idx;
      jtlb_data_din = {refill_data, refill_data};
    end else if (lkup_gnt) begin
      jtlb_data_cen = 1'b1;
      sel_idx       = lkup_idx;
    end
  end

  assign jtlb_data_idx = {{PadW{1'b0}}, sel_idx};

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      lkup_data_vld_q <= 1'b0;
    end else begin
      lkup_data_vld_q <= lkup_gnt;
    end
  end

  assign lkup_data_vld = lkup_data_vld_q;

`ifdef AQ_MMU_JTLB_DATA_HOLD_EN
  logic [2*WAY_W-1:0] lkup_hold_q;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      lkup_hold_q <= '0;
    end else if (lkup_data_vld_q) begin
      lkup_hold_q <= jtlb_data_dout;
    end
  end

  // Live array data in the valid cycle, captured copy afterwards.
  assign lkup_data = lkup_data_vld_q ? jtlb_data_dout : lkup_hold_q;
`else
  assign lkup_data = jtlb_data_dout;
`endif

endmodule
